// File: rtl/trace_capture.sv
// Architectural trace capture: stamps register/memory writes into a FWFT FIFO
// and ends the test on a tohost store or timeout.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   rf_we/rf_addr/rf_data   : register-file write events
//   mem_we/mem_addr/mem_wdata : data-memory store events
//   out_valid/out_ready     : trace head handshake
//   out_kind/out_cycle/out_addr/out_data : head entry fields
//   drop_cnt                : saturating count of events lost to a full FIFO
//   done/pass               : end-of-test status
module trace_capture #(
  parameter int XLEN = 32,
  parameter int DEPTH = 16,
  parameter int CYC_W = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(32'h0000_1000),
  parameter int TIMEOUT = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rf_we,
  input  logic [4:0]       rf_addr,
  input  logic [XLEN-1:0]  rf_data,
  input  logic             mem_we,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_kind,
  output logic [CYC_W-1:0] out_cycle,
  output logic [XLEN-1:0]  out_addr,
  output logic [XLEN-1:0]  out_data,
  output logic [15:0]      drop_cnt,
  output logic             done,
  output logic             pass
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int SW = OW + 1;

  typedef struct packed {
    logic             kind;
    logic [CYC_W-1:0] cyc;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  data;
  } entry_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  entry_t           fifo_q [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [OW-1:0]    occ;
  logic [CYC_W-1:0] cyc;
  logic             pass_lat;

  logic          run_st;
  logic          reg_ev;
  logic          mem_ev;
  logic          tohost;
  logic          tmo;
  logic          pop;
  logic [SW-1:0] space;
  logic          acc_reg;
  logic          acc_mem;
  logic [1:0]    n_push;
  logic [1:0]    n_drop;
  logic [OW-1:0] occ_nxt;
  logic [16:0]   drop_sum;
  entry_t        reg_ent;
  entry_t        mem_ent;
  entry_t        slot0;
  entry_t        head;

  assign run_st = (state == RUN);
  assign reg_ev = run_st && rf_we && (rf_addr != 5'd0);
  assign mem_ev = run_st && mem_we;
  assign tohost = mem_ev && (mem_addr == TOHOST_ADDR);
  assign tmo    = run_st && (cyc == CYC_W'(TIMEOUT - 1));

  assign out_valid = (occ != '0);
  assign pop       = out_valid && out_ready;

  // A pop this cycle frees its slot for this cycle's pushes.
  assign space = SW'(DEPTH) - SW'(occ) + SW'(pop);

  // Register event has priority over the memory event for free slots.
  assign acc_reg = reg_ev && (space != '0);
  assign acc_mem = mem_ev &&
                   (acc_reg ? (space >= SW'(2)) : (space != '0));

  assign n_push = 2'(acc_reg) + 2'(acc_mem);
  assign n_drop = 2'(reg_ev && !acc_reg) + 2'(mem_ev && !acc_mem);
  assign occ_nxt = occ + OW'(n_push) - OW'(pop);
  assign drop_sum = {1'b0, drop_cnt} + 17'(n_drop);

  always_comb begin
    reg_ent      = '0;
    reg_ent.kind = 1'b0;
    reg_ent.cyc  = cyc;
    reg_ent.addr = XLEN'(rf_addr);
    reg_ent.data = rf_data;
    mem_ent      = '0;
    mem_ent.kind = 1'b1;
    mem_ent.cyc  = cyc;
    mem_ent.addr = mem_addr;
    mem_ent.data = mem_wdata;
    slot0        = acc_reg ? reg_ent : mem_ent;
  end

  // Storage needs no reset; pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (n_push != 2'd0) begin
      fifo_q[wr_ptr] <= slot0;
    end
    if (acc_reg && acc_mem) begin
      fifo_q[wr_ptr + AW'(1)] <= mem_ent;
    end
  end

  assign head      = fifo_q[rd_ptr];
  assign out_kind  = head.kind;
  assign out_cycle = head.cyc;
  assign out_addr  = head.addr;
  assign out_data  = head.data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      drop_cnt <= '0;
    end else begin
      if (cyc != '1) begin
        cyc <= cyc + CYC_W'(1);
      end
      wr_ptr <= wr_ptr + AW'(n_push);
      rd_ptr <= rd_ptr + AW'(pop);
      occ    <= occ_nxt;
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      pass_lat <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (tohost) begin
            state    <= DRAIN;
            pass_lat <= (mem_wdata == XLEN'(1));
          end else if (tmo) begin
            state    <= DRAIN;
            pass_lat <= 1'b0;
          end
        end
        DRAIN: begin
          // Post-pop occupancy lets done rise right after the last pop.
          if (occ_nxt == '0) begin
            state <= DONE;
            done  <= 1'b1;
            pass  <= pass_lat;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: table vectors plus multi-cycle
// sequences for full FIFO, tohost drain, timeout and mid-run reset.
module tb_trace_capture;

  logic        clk;
  logic        rst_n;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        out_valid;
  logic        out_ready;
  logic        out_kind;
  logic [31:0] out_cycle;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [15:0] drop_cnt;
  logic        done;
  logic        pass;

  int checks;
  int errors;

  trace_capture #(
    .XLEN(32),
    .DEPTH(16),
    .CYC_W(32),
    .TOHOST_ADDR(32'h0000_1000),
    .TIMEOUT(100)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rf_we(rf_we),
    .rf_addr(rf_addr),
    .rf_data(rf_data),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_kind(out_kind),
    .out_cycle(out_cycle),
    .out_addr(out_addr),
    .out_data(out_data),
    .drop_cnt(drop_cnt),
    .done(done),
    .pass(pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic        mw;
    logic [31:0] ma;
    logic [31:0] md;
    logic        rdy;
    logic        ev;
    logic        ek;
    logic [31:0] ec;
    logic [31:0] ea;
    logic [31:0] ed;
  } vec_t;

  vec_t tv [11];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic we, input logic [4:0] a,
                     input logic [31:0] d, input logic mw,
                     input logic [31:0] ma, input logic [31:0] md,
                     input logic rdy);
    rf_we     = we;
    rf_addr   = a;
    rf_data   = d;
    mem_we    = mw;
    mem_addr  = ma;
    mem_wdata = md;
    out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one delta after the reset edge: cycle 0.
  task automatic do_reset();
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
  endtask

  task automatic run_tohost(input logic [31:0] val, input logic exp_pass);
    logic [31:0] ed [4];
    logic [31:0] ea [4];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drv(1, 5'(i + 1), 32'h10 + 32'(i), 0, 0, 0, 0);
      step();
    end
    drv(0, 0, 0, 1, 32'h0000_1000, val, 0);
    step();
    ed[0] = 32'h10; ed[1] = 32'h11; ed[2] = 32'h12; ed[3] = val;
    ea[0] = 32'd1;  ea[1] = 32'd2;  ea[2] = 32'd3;  ea[3] = 32'h1000;
    for (int k = 0; k < 4; k++) begin
      chk("th_valid", 64'(out_valid), 64'd1);
      chk("th_kind", 64'(out_kind), (k == 3) ? 64'd1 : 64'd0);
      chk("th_addr", 64'(out_addr), 64'(ea[k]));
      chk("th_data", 64'(out_data), 64'(ed[k]));
      chk("th_done_early", 64'(done), 64'd0);
      drv(k == 0, 5'd9, 32'h9, 0, 0, 0, 1);
      step();
    end
    chk("th_empty", 64'(out_valid), 64'd0);
    chk("th_done", 64'(done), 64'd1);
    chk("th_pass", 64'(pass), 64'(exp_pass));
    chk("th_drop", 64'(drop_cnt), 64'd0);
    for (int k = 0; k < 2; k++) begin
      drv(1, 5'd2, 32'h5, 1, 32'h1000, 32'h1, 1);
      step();
    end
    chk("done_hold_valid", 64'(out_valid), 64'd0);
    chk("done_hold", 64'(done), 64'd1);
    chk("done_hold_pass", 64'(pass), 64'(exp_pass));
  endtask

  initial begin
    logic [31:0] exp_q [16];
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);

    tv[0]  = '{0, 5'd0, 32'h0,  0, 32'h0,  32'h0,  1, 0, 0, 0, 0, 0};
    tv[1]  = '{0, 5'd0, 32'h0,  0, 32'h0,  32'h0,  1, 0, 0, 0, 0, 0};
    tv[2]  = '{0, 5'd0, 32'h0,  0, 32'h0,  32'h0,  1, 0, 0, 0, 0, 0};
    tv[3]  = '{1, 5'd5, 32'hA,  0, 32'h0,  32'h0,  1, 1, 0, 3, 5, 32'hA};
    tv[4]  = '{1, 5'd7, 32'h11, 1, 32'h40, 32'h22, 1, 1, 0, 4, 7, 32'h11};
    tv[5]  = '{0, 5'd0, 32'h0,  0, 32'h0,  32'h0,  1, 1, 1, 4, 32'h40, 32'h22};
    tv[6]  = '{1, 5'd0, 32'h99, 0, 32'h0,  32'h0,  1, 0, 0, 0, 0, 0};
    tv[7]  = '{1, 5'd3, 32'h33, 0, 32'h0,  32'h0,  0, 1, 0, 7, 3, 32'h33};
    tv[8]  = '{0, 5'd0, 32'h0,  1, 32'h80, 32'h44, 0, 1, 0, 7, 3, 32'h33};
    tv[9]  = '{0, 5'd0, 32'h0,  0, 32'h0,  32'h0,  1, 1, 1, 8, 32'h80, 32'h44};
    tv[10] = '{0, 5'd0, 32'h0,  0, 32'h0,  32'h0,  1, 0, 0, 0, 0, 0};

    do_reset();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);

    for (int i = 0; i < 11; i++) begin
      drv(tv[i].we, tv[i].ra, tv[i].rd, tv[i].mw, tv[i].ma, tv[i].md,
          tv[i].rdy);
      step();
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(tv[i].ev));
      if (tv[i].ev) begin
        chk($sformatf("v%0d_kind", i), 64'(out_kind), 64'(tv[i].ek));
        chk($sformatf("v%0d_cyc", i), 64'(out_cycle), 64'(tv[i].ec));
        chk($sformatf("v%0d_addr", i), 64'(out_addr), 64'(tv[i].ea));
        chk($sformatf("v%0d_data", i), 64'(out_data), 64'(tv[i].ed));
      end
      chk($sformatf("v%0d_drop", i), 64'(drop_cnt), 64'd0);
      chk($sformatf("v%0d_done", i), 64'(done), 64'd0);
    end

    // Fill past capacity, then pop+push on a full FIFO.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      drv(1, 5'd1, 32'(i), 0, 0, 0, 0);
      step();
    end
    chk("full_valid", 64'(out_valid), 64'd1);
    chk("full_drop", 64'(drop_cnt), 64'd2);
    chk("full_head", 64'(out_data), 64'd0);
    chk("full_cyc", 64'(out_cycle), 64'd0);
    drv(1, 5'd0, 32'h77, 0, 0, 0, 0);
    step();
    chk("x0_drop", 64'(drop_cnt), 64'd2);
    drv(1, 5'd1, 32'h100, 0, 0, 0, 1);
    step();
    chk("pp_drop", 64'(drop_cnt), 64'd2);
    chk("pp_head", 64'(out_data), 64'd1);
    drv(1, 5'd1, 32'h200, 1, 32'h40, 32'h300, 1);
    step();
    chk("pp2_drop", 64'(drop_cnt), 64'd3);
    chk("pp2_head", 64'(out_data), 64'd2);
    for (int k = 0; k < 14; k++) exp_q[k] = 32'(k + 2);
    exp_q[14] = 32'h100;
    exp_q[15] = 32'h200;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("drain%0d_data", k), 64'(out_data), 64'(exp_q[k]));
      drv(0, 0, 0, 0, 0, 0, 1);
      step();
    end
    chk("drain_empty", 64'(out_valid), 64'd0);

    run_tohost(32'h1, 1'b1);
    run_tohost(32'h2, 1'b0);

    // Reset while entries are queued and the consumer is ready.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drv(1, 5'd1, 32'(i), 0, 0, 0, 0);
      step();
    end
    chk("mr_pre_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    drv(1, 5'd2, 32'h5, 0, 0, 0, 1);
    step();
    rst_n = 1'b1;
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_drop", 64'(drop_cnt), 64'd0);
    chk("mr_done", 64'(done), 64'd0);
    drv(1, 5'd3, 32'h3, 0, 0, 0, 0);
    step();
    chk("mr_cyc", 64'(out_cycle), 64'd0);
    chk("mr_addr", 64'(out_addr), 64'd3);

    // Timeout at counter 99.
    do_reset();
    for (int i = 0; i < 98; i++) begin
      drv(0, 0, 0, 0, 0, 0, 1);
      step();
    end
    drv(1, 5'd4, 32'h98, 0, 0, 0, 1);
    step();
    chk("to_head_cyc", 64'(out_cycle), 64'd98);
    chk("to_head_addr", 64'(out_addr), 64'd4);
    chk("to_done0", 64'(done), 64'd0);
    drv(1, 5'd6, 32'h99, 0, 0, 0, 1);
    step();
    chk("to_last_valid", 64'(out_valid), 64'd1);
    chk("to_last_cyc", 64'(out_cycle), 64'd99);
    chk("to_last_data", 64'(out_data), 64'h99);
    chk("to_done1", 64'(done), 64'd0);
    drv(1, 5'd8, 32'h100, 1, 32'h1000, 32'h1, 1);
    step();
    chk("to_empty", 64'(out_valid), 64'd0);
    chk("to_done", 64'(done), 64'd1);
    chk("to_pass", 64'(pass), 64'd0);
    chk("to_drop", 64'(drop_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 Parameter XLEN, default 32, data/address width of captured events.
REQ-002 Parameter DEPTH, default 16, trace FIFO entries; power of two, >= 2.
REQ-003 Parameter CYC_W, default 32, cycle-stamp width.
REQ-004 Parameter TOHOST_ADDR, default 32'h0000_1000, end-of-test store address.
REQ-005 Parameter TIMEOUT, default 100, cycles before forced end of test.
REQ-006 clk  in  1  single clock, all state on rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 rf_we  in  1  register-file write strobe.
REQ-009 rf_addr  in  5  destination register index.
REQ-010 rf_data  in  XLEN  register write data.
REQ-011 mem_we  in  1  data-memory write strobe.
REQ-012 mem_addr  in  XLEN  store address.
REQ-013 mem_wdata  in  XLEN  store data.
REQ-014 out_valid  out  1  trace entry available at head.
REQ-015 out_ready  in  1  consumer accepts head entry.
REQ-016 out_kind  out  1  0 = register write, 1 = memory write.
REQ-017 out_cycle  out  CYC_W  cycle stamp of head entry.
REQ-018 out_addr  out  XLEN  register index (zero-extended) or store address.
REQ-019 out_data  out  XLEN  written data.
REQ-020 drop_cnt  out  16  events lost to a full FIFO, saturating.
REQ-021 done  out  1  test finished and FIFO drained.
REQ-022 pass  out  1  valid when done: tohost store carried value 1.

Function
REQ-023 Free-running cycle counter: 0 in the first cycle after reset, +1 per cycle, saturates at all-ones; each captured event stamped with the counter value of its capture cycle.
REQ-024 States: RUN, DRAIN, DONE; reset enters RUN.
REQ-025 RUN: capture rf_we with rf_addr != 0 as kind 0; rf_we with rf_addr == 0 ignored, not counted as dropped.
REQ-026 RUN: capture every mem_we as kind 1.
REQ-027 Both events in one cycle: register entry queued ahead of memory entry; up to two pushes per cycle.
REQ-028 FIFO is first-word-fall-through: out_valid = occupancy != 0; head fields stable while out_valid && !out_ready.
REQ-029 Pop when out_valid && out_ready; a pop frees its slot for pushes in the same cycle (space = DEPTH - occupancy + pop).
REQ-030 Insufficient space: entries accepted in priority order (register first) until full; each rejected entry increments drop_cnt by 1, saturating at 16'hFFFF.
REQ-031 RUN -> DRAIN on mem_we with mem_addr == TOHOST_ADDR; that store is itself captured (subject to space); pass latched = (mem_wdata == 1).
REQ-032 RUN -> DRAIN when the cycle counter equals TIMEOUT-1 without a tohost store; pass latched 0; tohost in the same cycle takes precedence.
REQ-033 DRAIN: no capture, no drop counting; pops continue; -> DONE in the cycle after occupancy reaches 0 (next-state evaluated on post-pop occupancy).
REQ-034 DONE: terminal until reset; done = 1; pass holds latched value; inputs ignored.
REQ-035 Write/read pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy is log2(DEPTH)+1 bits so full (DEPTH) and empty (0) are distinct.

Reset
REQ-036 rst_n low at a rising edge: state RUN, cycle counter 0, FIFO empty, out_valid 0, drop_cnt 0, done 0, pass 0.
REQ-037 Reset mid-RUN or mid-DRAIN discards all queued entries; no entry pops during the reset cycle.
REQ-038 out_kind/out_cycle/out_addr/out_data are don't-care while out_valid = 0.

Verification
REQ-039 Cycle 3: rf_we, rf_addr 5, rf_data 32'h0000_000A; out_ready 1 -> next cycle out_valid 1, kind 0, addr 5, data 32'h0000_000A, cycle 3.
REQ-040 Same cycle: rf_we x7 = 32'h11 and mem_we [32'h40] = 32'h22 -> two entries, register first, identical stamps.
REQ-041 out_ready 0, DEPTH=16, 18 register writes to x1 -> 16 entries held, drop_cnt = 2; rf_we to x0 -> no entry, drop_cnt unchanged.
REQ-042 FIFO full, then pop plus one push in the same cycle -> push accepted, occupancy stays 16, drop_cnt unchanged.
REQ-043 Store 32'h1 to 32'h0000_1000 with 3 entries queued, out_ready 1 -> 4 entries drained in order, done 1 the cycle after the last pop, pass 1; store value 2 instead -> pass 0.
REQ-044 No tohost store, TIMEOUT=100 -> DRAIN entered when the counter equals 99, done after drain, pass 0; events after that edge ignored.
